// File: rtl/encode_packet.sv
// Transmit-side USB packet encoder. Turns handshake and data-packet requests from the
// transfer layer into a byte stream (PID, payload, CRC16) on an AXI4-Stream towards ULPI.
module encode_packet #(
    parameter int unsigned MAX_PACKET_SIZE = 512
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] tx_trn_hsk_type,
    input  logic       tx_trn_send_hsk,
    output logic       tx_trn_hsk_sent,
    input  logic [1:0] tx_trn_data_type,
    input  logic       tx_trn_data_start,
    input  logic [7:0] tx_trn_data,
    input  logic       tx_trn_data_valid,
    output logic       tx_trn_data_ready,
    input  logic       tx_trn_data_last,
    output logic       axis_tx_tvalid_o,
    input  logic       axis_tx_tready_i,
    output logic       axis_tx_tlast_o,
    output logic [7:0] axis_tx_tdata_o,
    output logic       tx_busy_o,
    output logic       tx_overflow_o
);

    // Index of the final payload byte that fits; the beat at this count ends the payload.
    localparam logic [10:0] LastIdx = 11'(MAX_PACKET_SIZE - 1);

    typedef enum logic [2:0] {
        StIdle,
        StHsk,
        StPid,
        StData,
        StCrcLo,
        StCrcHi
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] crc_q, crc_d;
    logic [10:0] count_q, count_d;
    // PIDs are captured at request time so the byte stays stable while the sink stalls.
    logic [7:0]  hsk_pid_q, hsk_pid_d;
    logic [7:0]  data_pid_q, data_pid_d;
    logic        beat;

    // One byte of reflected CRC16 (poly 0x8005, LSB-first form 0xA001).
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
        logic [15:0] c;
        c = crc ^ {8'h00, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
        end
        return c;
    endfunction

    function automatic logic [7:0] hsk_pid(input logic [1:0] hsk_type);
        logic [3:0] pid;
        unique case (hsk_type)
            2'b00:   pid = 4'h2;  // ACK
            2'b01:   pid = 4'h6;  // NYET
            2'b10:   pid = 4'hA;  // NAK
            default: pid = 4'hE;  // STALL
        endcase
        return {~pid, pid};
    endfunction

    function automatic logic [7:0] data_pid(input logic [1:0] data_type);
        logic [3:0] pid;
        unique case (data_type)
            2'b00:   pid = 4'h3;  // DATA0
            2'b01:   pid = 4'hB;  // DATA1
            2'b10:   pid = 4'h7;  // DATA2
            default: pid = 4'hF;  // MDATA
        endcase
        return {~pid, pid};
    endfunction

    // State, CRC, byte counter and captured PIDs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= StIdle;
            crc_q      <= 16'hFFFF;
            count_q    <= 11'd0;
            hsk_pid_q  <= 8'h00;
            data_pid_q <= 8'h00;
        end else begin
            state_q    <= state_d;
            crc_q      <= crc_d;
            count_q    <= count_d;
            hsk_pid_q  <= hsk_pid_d;
            data_pid_q <= data_pid_d;
        end
    end

    // Next-state logic and stream outputs; DATA is a zero-latency pass-through.
    always_comb begin
        state_d           = state_q;
        crc_d             = crc_q;
        count_d           = count_q;
        hsk_pid_d         = hsk_pid_q;
        data_pid_d        = data_pid_q;
        beat              = 1'b0;
        tx_trn_hsk_sent   = 1'b0;
        tx_trn_data_ready = 1'b0;
        axis_tx_tvalid_o  = 1'b0;
        axis_tx_tlast_o   = 1'b0;
        axis_tx_tdata_o   = 8'h00;
        tx_overflow_o     = 1'b0;

        unique case (state_q)
            StIdle: begin
                // Handshake wins; a simultaneous data request stays pending until IDLE again.
                if (tx_trn_send_hsk) begin
                    hsk_pid_d = hsk_pid(tx_trn_hsk_type);
                    state_d   = StHsk;
                end else if (tx_trn_data_start) begin
                    data_pid_d = data_pid(tx_trn_data_type);
                    state_d    = StPid;
                end
            end
            StHsk: begin
                axis_tx_tvalid_o = 1'b1;
                axis_tx_tdata_o  = hsk_pid_q;
                axis_tx_tlast_o  = 1'b1;
                if (axis_tx_tready_i) begin
                    tx_trn_hsk_sent = 1'b1;
                    state_d         = StIdle;
                end
            end
            StPid: begin
                axis_tx_tvalid_o = 1'b1;
                axis_tx_tdata_o  = data_pid_q;
                if (axis_tx_tready_i) begin
                    crc_d   = 16'hFFFF;
                    count_d = 11'd0;
                    state_d = StData;
                end
            end
            StData: begin
                axis_tx_tvalid_o  = tx_trn_data_valid;
                axis_tx_tdata_o   = tx_trn_data;
                tx_trn_data_ready = axis_tx_tready_i;
                beat              = tx_trn_data_valid && axis_tx_tready_i;
                if (beat) begin
                    crc_d   = crc16_byte(crc_q, tx_trn_data);
                    count_d = count_q + 11'd1;
                    if (tx_trn_data_last) begin
                        state_d = StCrcLo;
                    end else if (count_q == LastIdx) begin
                        tx_overflow_o = 1'b1;
                        state_d       = StCrcLo;
                    end else if (!tx_trn_data_start) begin
                        state_d = StCrcLo;
                    end
                end else if (!tx_trn_data_start) begin
                    // Covers both the zero-length packet and a source that drops start early.
                    state_d = StCrcLo;
                end
            end
            StCrcLo: begin
                axis_tx_tvalid_o = 1'b1;
                axis_tx_tdata_o  = ~crc_q[7:0];
                if (axis_tx_tready_i) begin
                    state_d = StCrcHi;
                end
            end
            StCrcHi: begin
                axis_tx_tvalid_o = 1'b1;
                axis_tx_tdata_o  = ~crc_q[15:8];
                axis_tx_tlast_o  = 1'b1;
                if (axis_tx_tready_i) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign tx_busy_o = (state_q != StIdle);

endmodule

// File: tb/tb_encode_packet.sv
// Bench for encode_packet: table-driven directed packets, randomized packets against a
// byte-list reference model, plus hand sequences for request collision and mid-packet reset.
module tb_encode_packet;

    localparam int Max = 8;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] tx_trn_hsk_type = 2'b00;
    logic       tx_trn_send_hsk = 1'b0;
    logic       tx_trn_hsk_sent;
    logic [1:0] tx_trn_data_type = 2'b00;
    logic       tx_trn_data_start = 1'b0;
    logic [7:0] tx_trn_data = 8'h00;
    logic       tx_trn_data_valid = 1'b0;
    logic       tx_trn_data_ready;
    logic       tx_trn_data_last = 1'b0;
    logic       axis_tx_tvalid_o;
    logic       axis_tx_tready_i = 1'b0;
    logic       axis_tx_tlast_o;
    logic [7:0] axis_tx_tdata_o;
    logic       tx_busy_o;
    logic       tx_overflow_o;

    encode_packet #(.MAX_PACKET_SIZE(Max)) dut (
        .clock             (clock),
        .reset             (reset),
        .tx_trn_hsk_type   (tx_trn_hsk_type),
        .tx_trn_send_hsk   (tx_trn_send_hsk),
        .tx_trn_hsk_sent   (tx_trn_hsk_sent),
        .tx_trn_data_type  (tx_trn_data_type),
        .tx_trn_data_start (tx_trn_data_start),
        .tx_trn_data       (tx_trn_data),
        .tx_trn_data_valid (tx_trn_data_valid),
        .tx_trn_data_ready (tx_trn_data_ready),
        .tx_trn_data_last  (tx_trn_data_last),
        .axis_tx_tvalid_o  (axis_tx_tvalid_o),
        .axis_tx_tready_i  (axis_tx_tready_i),
        .axis_tx_tlast_o   (axis_tx_tlast_o),
        .axis_tx_tdata_o   (axis_tx_tdata_o),
        .tx_busy_o         (tx_busy_o),
        .tx_overflow_o     (tx_overflow_o)
    );

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;

    bit         ready_rand = 1'b0;
    bit         chk_en = 1'b0;
    bit         prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic       prev_last = 1'b0;
    int         ovf_cnt = 0;
    int         hsk_cnt = 0;

    logic [8:0] exp_q[$];
    logic [8:0] got_q[$];
    logic [7:0] pl[16];

    typedef struct {
        bit         hsk;
        logic [1:0] typ;
        int         len;
        bit         stall;
        logic [7:0] pid;
        bit         ovf;
    } vec_t;

    vec_t tbl[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Reference: PID is {~nibble, nibble} from the USB PID tables.
    function automatic logic [7:0] pid_of(input bit hsk, input logic [1:0] t);
        logic [3:0] hn[4];
        logic [3:0] dn[4];
        logic [3:0] n;
        hn = '{4'h2, 4'h6, 4'hA, 4'hE};
        dn = '{4'h3, 4'hB, 4'h7, 4'hF};
        n  = hsk ? hn[t] : dn[t];
        return {~n, n};
    endfunction

    // Reference CRC16, processed one bit at a time, LSB first.
    function automatic logic [15:0] crc_bits(input logic [15:0] init, input logic [7:0] b);
        logic [15:0] c;
        bit fb;
        c = init;
        for (int k = 0; k < 8; k++) begin
            fb = c[0] ^ b[k];
            c  = c >> 1;
            if (fb) c = c ^ 16'hA001;
        end
        return c;
    endfunction

    task automatic model_hsk(input logic [7:0] pid);
        exp_q.push_back({1'b1, pid});
    endtask

    task automatic model_data(input logic [7:0] pid, input int n);
        logic [15:0] c;
        int m;
        m = (n > Max) ? Max : n;
        c = 16'hFFFF;
        exp_q.push_back({1'b0, pid});
        for (int i = 0; i < m; i++) begin
            exp_q.push_back({1'b0, pl[i]});
            c = crc_bits(c, pl[i]);
        end
        exp_q.push_back({1'b0, ~c[7:0]});
        exp_q.push_back({1'b1, ~c[15:8]});
    endtask

    // Sink ready: always high, or random stalls.
    always @(posedge clock) begin
        #1;
        axis_tx_tready_i = ready_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
    end

    // Stream monitor: collects beats, counts pulses, checks AXIS hold rule.
    always @(negedge clock) begin
        if (axis_tx_tvalid_o && axis_tx_tready_i) got_q.push_back({axis_tx_tlast_o, axis_tx_tdata_o});
        if (tx_overflow_o) ovf_cnt++;
        if (tx_trn_hsk_sent) hsk_cnt++;
        if (chk_en && prev_stall) begin
            check("hold tvalid", {31'd0, axis_tx_tvalid_o}, 32'd1);
            check("hold tdata", {24'd0, axis_tx_tdata_o}, {24'd0, prev_data});
            check("hold tlast", {31'd0, axis_tx_tlast_o}, {31'd0, prev_last});
        end
        prev_stall = chk_en && axis_tx_tvalid_o && !axis_tx_tready_i;
        prev_data  = axis_tx_tdata_o;
        prev_last  = axis_tx_tlast_o;
    end

    task automatic send_hsk(input logic [1:0] t);
        bit acc;
        acc = 1'b0;
        tx_trn_hsk_type = t;
        tx_trn_send_hsk = 1'b1;
        for (int w = 0; w < 200 && !acc; w++) begin
            @(negedge clock);
            acc = tx_trn_hsk_sent;
            @(posedge clock);
            #1;
        end
        tx_trn_send_hsk = 1'b0;
        if (!acc) check("hsk_sent timeout", 32'd0, 32'd1);
    endtask

    // Drives a packet of n source bytes; only the first Max can be taken by the encoder.
    task automatic send_data(input logic [1:0] t, input int n, input bit gaps);
        bit acc;
        int m;
        m = (n > Max) ? Max : n;
        tx_trn_data_type  = t;
        tx_trn_data_start = 1'b1;
        if (n == 0) begin
            repeat (3) @(posedge clock);
            #1;
        end
        for (int i = 0; i < m; i++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                tx_trn_data_valid = 1'b0;
                @(posedge clock);
                #1;
            end
            tx_trn_data_valid = 1'b1;
            tx_trn_data       = pl[i];
            tx_trn_data_last  = (i == n - 1);
            acc = 1'b0;
            for (int w = 0; w < 200 && !acc; w++) begin
                @(negedge clock);
                acc = tx_trn_data_ready;
                @(posedge clock);
                #1;
            end
            if (!acc) begin
                check("data_ready timeout", 32'd0, 32'd1);
                break;
            end
        end
        tx_trn_data_valid = 1'b0;
        tx_trn_data_last  = 1'b0;
        tx_trn_data_start = 1'b0;
    endtask

    // Waits for the encoder to go idle, then compares stream, residual, and pulse counts.
    task automatic finish_and_compare(input string name, input int hsk0, input int exp_hsk,
                                      input int ovf0, input int exp_ovf, input bit has_data);
        bit done;
        int nb;
        logic [15:0] c;
        done = 1'b0;
        for (int w = 0; w < 400 && !done; w++) begin
            @(negedge clock);
            done = !tx_busy_o && (got_q.size() >= exp_q.size());
        end
        if (!done) check({name, " idle timeout"}, 32'd0, 32'd1);
        check({name, " beats"}, got_q.size(), exp_q.size());
        nb = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < nb; i++) begin
            check($sformatf("%s byte%0d", name, i), {23'd0, got_q[i]}, {23'd0, exp_q[i]});
        end
        // CRC over payload plus the two sent CRC bytes must leave the USB residual.
        if (has_data && got_q.size() >= 3 && got_q[got_q.size() - 1][8]) begin
            c = 16'hFFFF;
            for (int i = got_q.size() - 1; i > 0 && !(got_q[i - 1][8] && i - 1 > 0); i--) begin
            end
            for (int i = (exp_q[0][8] ? 2 : 1); i < got_q.size(); i++) c = crc_bits(c, got_q[i][7:0]);
            check({name, " crc residual"}, {16'd0, c}, 32'h0000B001);
        end
        check({name, " hsk_sent pulses"}, hsk_cnt - hsk0, exp_hsk);
        check({name, " overflow pulses"}, ovf_cnt - ovf0, exp_ovf);
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int h0;
        int o0;
        bit is_hsk;
        logic [1:0] t;
        int n;

        tbl[0] = '{1'b1, 2'd0, 0,  1'b0, 8'hD2, 1'b0};
        tbl[1] = '{1'b1, 2'd1, 0,  1'b1, 8'h96, 1'b0};
        tbl[2] = '{1'b1, 2'd2, 0,  1'b1, 8'h5A, 1'b0};
        tbl[3] = '{1'b1, 2'd3, 0,  1'b1, 8'h1E, 1'b0};
        tbl[4] = '{1'b0, 2'd0, 0,  1'b0, 8'hC3, 1'b0};
        tbl[5] = '{1'b0, 2'd1, 4,  1'b1, 8'h4B, 1'b0};
        tbl[6] = '{1'b0, 2'd2, 8,  1'b1, 8'h87, 1'b0};
        tbl[7] = '{1'b0, 2'd3, 10, 1'b0, 8'h0F, 1'b1};
        tbl[8] = '{1'b0, 2'd0, 1,  1'b1, 8'hC3, 1'b0};
        tbl[9] = '{1'b0, 2'd1, 9,  1'b1, 8'h4B, 1'b1};

        // Reset state.
        repeat (3) @(posedge clock);
        #1;
        check("reset tvalid", {31'd0, axis_tx_tvalid_o}, 32'd0);
        check("reset tlast", {31'd0, axis_tx_tlast_o}, 32'd0);
        check("reset tdata", {24'd0, axis_tx_tdata_o}, 32'd0);
        check("reset busy", {31'd0, tx_busy_o}, 32'd0);
        check("reset overflow", {31'd0, tx_overflow_o}, 32'd0);
        check("reset hsk_sent", {31'd0, tx_trn_hsk_sent}, 32'd0);
        check("reset data_ready", {31'd0, tx_trn_data_ready}, 32'd0);
        reset  = 1'b0;
        chk_en = 1'b1;
        @(posedge clock);
        #1;

        // Directed table.
        for (int r = 0; r < 10; r++) begin
            for (int i = 0; i < 16; i++) pl[i] = 8'(i);
            ready_rand = tbl[r].stall;
            h0 = hsk_cnt;
            o0 = ovf_cnt;
            if (tbl[r].hsk) begin
                model_hsk(tbl[r].pid);
                send_hsk(tbl[r].typ);
            end else begin
                model_data(tbl[r].pid, tbl[r].len);
                send_data(tbl[r].typ, tbl[r].len, tbl[r].stall);
            end
            finish_and_compare($sformatf("row%0d", r), h0, tbl[r].hsk ? 1 : 0,
                               o0, tbl[r].ovf ? 1 : 0, !tbl[r].hsk);
        end

        // Handshake and data request raised in the same cycle.
        for (int i = 0; i < 16; i++) pl[i] = 8'hA0 + 8'(i);
        ready_rand = 1'b1;
        h0 = hsk_cnt;
        o0 = ovf_cnt;
        model_hsk(8'h1E);
        model_data(8'h87, 3);
        fork
            send_hsk(2'd3);
            send_data(2'd2, 3, 1'b0);
        join
        finish_and_compare("collision", h0, 1, o0, 0, 1'b1);

        // Randomized packets.
        for (int p = 0; p < 40; p++) begin
            is_hsk = ($urandom_range(0, 3) == 0);
            t      = 2'($urandom_range(0, 3));
            n      = $urandom_range(0, 12);
            for (int i = 0; i < 16; i++) pl[i] = 8'($urandom);
            ready_rand = $urandom_range(0, 1) != 0;
            h0 = hsk_cnt;
            o0 = ovf_cnt;
            if (is_hsk) begin
                model_hsk(pid_of(1'b1, t));
                send_hsk(t);
            end else begin
                model_data(pid_of(1'b0, t), n);
                send_data(t, n, 1'b1);
            end
            finish_and_compare($sformatf("rand%0d", p), h0, is_hsk ? 1 : 0,
                               o0, (!is_hsk && n > Max) ? 1 : 0, !is_hsk);
        end

        // Reset in the middle of a data packet.
        ready_rand        = 1'b0;
        tx_trn_data_type  = 2'd1;
        tx_trn_data_start = 1'b1;
        tx_trn_data_valid = 1'b1;
        tx_trn_data       = 8'hAA;
        repeat (4) @(posedge clock);
        #1;
        check("midpkt busy", {31'd0, tx_busy_o}, 32'd1);
        chk_en = 1'b0;
        reset  = 1'b1;
        @(posedge clock);
        #1;
        check("reset tvalid next cycle", {31'd0, axis_tx_tvalid_o}, 32'd0);
        check("reset busy next cycle", {31'd0, tx_busy_o}, 32'd0);
        reset             = 1'b0;
        tx_trn_data_start = 1'b0;
        tx_trn_data_valid = 1'b0;
        @(posedge clock);
        #1;
        got_q.delete();
        chk_en = 1'b1;
        h0 = hsk_cnt;
        o0 = ovf_cnt;
        model_hsk(8'h5A);
        send_hsk(2'd2);
        finish_and_compare("after reset", h0, 1, o0, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
